// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial N-bit adder controller built around one full_adder cell
//
// full_adder      : one-bit adder cell (a, b, c_in -> sum, c_out).
// serial_add_ctrl : sequences full_adder over N-bit operands, LSB first, one bit per clock.
//   clk, rst        : clock, asynchronous active-high reset
//   start, a, b, c_in : request plus operands, sampled when accepted in IDLE or DONE
//   busy            : high while bits are being processed
//   done            : one-cycle completion pulse
//   s, c_out        : registered result, updated only when an addition completes

module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);
    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] s,
    output logic         c_out
);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   ra_q, ra_d;
    logic [N-1:0]   rb_q, rb_d;
    logic [N-1:0]   rs_q, rs_d;
    logic [N-1:0]   s_q, s_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           cy_q, cy_d;
    logic           c_out_q, c_out_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           fa_sum;
    logic           fa_cout;
    logic [N-1:0]   rs_shift;

    full_adder u_fa (
        .a     (ra_q[0]),
        .b     (rb_q[0]),
        .c_in  (cy_q),
        .sum   (fa_sum),
        .c_out (fa_cout)
    );

    // New sum bit enters at the MSB so that after N shifts bit 0 holds the LSB.
    generate
        if (N == 1) begin : g_rs_one
            assign rs_shift = fa_sum;
        end else begin : g_rs_many
            assign rs_shift = {fa_sum, rs_q[N-1:1]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rs_d    = rs_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        cy_d    = cy_q;
        c_out_d = c_out_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    ra_d    = a;
                    rb_d    = b;
                    cy_d    = c_in;
                    cnt_d   = '0;
                    rs_d    = '0;
                    state_d = ADD;
                end else begin
                    state_d = IDLE;
                end
            end
            ADD: begin
                rs_d  = rs_shift;
                cy_d  = fa_cout;
                ra_d  = ra_q >> 1;
                rb_d  = rb_q >> 1;
                cnt_d = cnt_q + CW'(1);
                // Last bit: publish the shifted value, which already includes this bit.
                if (cnt_q == CNT_LAST) begin
                    s_d     = rs_shift;
                    c_out_d = fa_cout;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Status flags are registered copies of the next state.
        busy_d = (state_d == ADD);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            rs_q    <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            cy_q    <= 1'b0;
            c_out_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rs_q    <= rs_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            cy_q    <= cy_d;
            c_out_q <= c_out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign s     = s_q;
    assign c_out = c_out_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed self-checking bench for serial_add_ctrl at N=8, N=1, N=2

module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       c8 = 1'b0;
    logic       busy8, done8, co8;
    logic [7:0] s8;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       c1 = 1'b0;
    logic       busy1, done1, co1;
    logic [0:0] s1;

    logic       start2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0;
    logic       c2 = 1'b0;
    logic       busy2, done2, co2;
    logic [1:0] s2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.N(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .c_in(c8),
        .busy(busy8), .done(done8), .s(s8), .c_out(co8)
    );
    serial_add_ctrl #(.N(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .c_in(c1),
        .busy(busy1), .done(done1), .s(s1), .c_out(co1)
    );
    serial_add_ctrl #(.N(2)) u2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .c_in(c2),
        .busy(busy2), .done(done2), .s(s2), .c_out(co2)
    );

    // Issue one N=8 operation; lat counts edges from acceptance (inclusive) to done visible.
    task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                        output int lat, output int bc, output logic [7:0] rs, output logic rc);
        @(negedge clk);
        a8 = ia; b8 = ib; c8 = ic; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        lat = 1; bc = 0;
        while (!done8 && lat < 40) begin
            if (busy8) bc++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        rs = s8; rc = co8;
    endtask

    task automatic run1(input logic [0:0] ia, input logic [0:0] ib, input logic ic,
                        output int lat, output logic [0:0] rs, output logic rc);
        @(negedge clk);
        a1 = ia; b1 = ib; c1 = ic; start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        lat = 1;
        while (!done1 && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        rs = s1; rc = co1;
    endtask

    task automatic run2(input logic [1:0] ia, input logic [1:0] ib, input logic ic,
                        output int lat, output logic [1:0] rs, output logic rc);
        @(negedge clk);
        a2 = ia; b2 = ib; c2 = ic; start2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start2 = 1'b0;
        lat = 1;
        while (!done2 && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        rs = s2; rc = co2;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++; if ({busy8, done8} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {busy8, done8}); end
        total++; if ({co8, s8} !== 9'h000) begin bad++; $display("FAIL reset_result got=%h exp=000", {co8, s8}); end
        total++; if ({busy1, done1, co1, s1, busy2, done2, co2, s2} !== 9'h000) begin
            bad++; $display("FAIL reset_small got=%b exp=0", {busy1, done1, co1, s1, busy2, done2, co2, s2});
        end
        rst = 1'b0;
        @(negedge clk);
        total++; if ({busy8, done8, co8, s8} !== 11'h000) begin bad++; $display("FAIL reset_release got=%h exp=000", {busy8, done8, co8, s8}); end
    endtask

    task automatic test_zero;
        int lat, bc;
        logic [7:0] rs;
        logic rc;
        run8(8'h00, 8'h00, 1'b0, lat, bc, rs, rc);
        total++; if (lat !== 9) begin bad++; $display("FAIL zero_latency got=%0d exp=9", lat); end
        total++; if (bc !== 8) begin bad++; $display("FAIL zero_busy_cycles got=%0d exp=8", bc); end
        total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL zero_busy_in_done got=%b exp=0", busy8); end
        total++; if ({rc, rs} !== 9'h000) begin bad++; $display("FAIL zero_sum got=%h exp=000", {rc, rs}); end
        @(negedge clk);
        total++; if (done8 !== 1'b0) begin bad++; $display("FAIL zero_done_single got=%b exp=0", done8); end
    endtask

    task automatic test_vectors;
        logic [7:0] va [3] = '{8'hFF, 8'hFF, 8'h5A};
        logic [7:0] vb [3] = '{8'h01, 8'hFF, 8'h3C};
        logic       vc [3] = '{1'b0, 1'b1, 1'b0};
        logic [8:0] ve [3] = '{9'h100, 9'h1FF, 9'h096};
        int lat, bc;
        logic [7:0] rs;
        logic rc;
        for (int i = 0; i < 3; i++) begin
            run8(va[i], vb[i], vc[i], lat, bc, rs, rc);
            total++; if ({rc, rs} !== ve[i]) begin bad++; $display("FAIL vector%0d got=%h exp=%h", i, {rc, rs}, ve[i]); end
            total++; if (lat !== 9) begin bad++; $display("FAIL vector%0d_latency got=%0d exp=9", i, lat); end
        end
    endtask

    task automatic test_ignore_start;
        int lat, extra;
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; c8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        total++; if ({co8, s8} !== 9'h096) begin bad++; $display("FAIL hold_prev_result got=%h exp=096", {co8, s8}); end
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = 3;
        while (!done8 && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        total++; if (lat !== 9) begin bad++; $display("FAIL ignore_latency got=%0d exp=9", lat); end
        total++; if ({co8, s8} !== 9'h046) begin bad++; $display("FAIL ignore_sum got=%h exp=046", {co8, s8}); end
        extra = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done8 || busy8) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL ignore_extra_activity got=%0d exp=0", extra); end
    endtask

    task automatic test_back_to_back;
        logic exp_done;
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h01; c8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 27; k++) begin
            @(negedge clk);
            exp_done = ((k % 9) == 8);
            total++; if ({busy8, done8} !== {~exp_done, exp_done}) begin
                bad++; $display("FAIL b2b_flags cycle=%0d got=%b exp=%b", k, {busy8, done8}, {~exp_done, exp_done});
            end
            if (exp_done) begin
                total++; if ({co8, s8} !== 9'h002) begin bad++; $display("FAIL b2b_sum cycle=%0d got=%h exp=002", k, {co8, s8}); end
            end
        end
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b exp=0", busy8); end
    endtask

    task automatic test_reset_mid;
        int lat, bc;
        logic [7:0] rs;
        logic rc;
        run8(8'h12, 8'h34, 1'b0, lat, bc, rs, rc);
        total++; if ({rc, rs} !== 9'h046) begin bad++; $display("FAIL rstmid_prior got=%h exp=046", {rc, rs}); end
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h01; c8 = 1'b1; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if ({busy8, done8, co8, s8} !== 11'h000) begin bad++; $display("FAIL rstmid_async got=%h exp=000", {busy8, done8, co8, s8}); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if ({busy8, done8, co8, s8} !== 11'h000) begin bad++; $display("FAIL rstmid_after got=%h exp=000", {busy8, done8, co8, s8}); end
        run8(8'h80, 8'h80, 1'b0, lat, bc, rs, rc);
        total++; if ({rc, rs} !== 9'h100) begin bad++; $display("FAIL rstmid_new got=%h exp=100", {rc, rs}); end
        total++; if (lat !== 9) begin bad++; $display("FAIL rstmid_latency got=%0d exp=9", lat); end
    endtask

    task automatic test_small_widths;
        int lat;
        logic [0:0] r1;
        logic [1:0] r2;
        logic rc;
        int e;
        for (int x = 0; x < 2; x++)
            for (int y = 0; y < 2; y++)
                for (int c = 0; c < 2; c++) begin
                    run1(1'(x), 1'(y), 1'(c), lat, r1, rc);
                    e = x + y + c;
                    total++; if ({rc, r1} !== 2'(e)) begin bad++; $display("FAIL n1_sum a=%0d b=%0d c=%0d got=%0d exp=%0d", x, y, c, {rc, r1}, e); end
                    total++; if (lat !== 2) begin bad++; $display("FAIL n1_latency got=%0d exp=2", lat); end
                end
        for (int x = 0; x < 4; x++)
            for (int y = 0; y < 4; y++)
                for (int c = 0; c < 2; c++) begin
                    run2(2'(x), 2'(y), 1'(c), lat, r2, rc);
                    e = x + y + c;
                    total++; if ({rc, r2} !== 3'(e)) begin bad++; $display("FAIL n2_sum a=%0d b=%0d c=%0d got=%0d exp=%0d", x, y, c, {rc, r2}, e); end
                    total++; if (lat !== 3) begin bad++; $display("FAIL n2_latency got=%0d exp=3", lat); end
                end
    endtask

    initial begin
        test_reset;
        test_zero;
        test_vectors;
        test_ignore_start;
        test_back_to_back;
        test_reset_mid;
        test_small_widths;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial addition controller that sequences a single `full_adder` instance across two N-bit operands, one bit per clock, LSB first. It loads operands on a start request, holds the running carry in a flip-flop, collects sum bits in a shift register, and reports a registered N-bit sum plus carry-out with a start/busy/done handshake. It sits between operand sources and consumers that need N-bit addition from the one-bit adder cell.

## Interface
- `N`, default 8: operand width in bits; legal range N >= 1.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  request to begin an addition; sampled only in IDLE or DONE.
- `a`  in  N  operand A; sampled on the edge that accepts `start`.
- `b`  in  N  operand B; sampled on the edge that accepts `start`.
- `c_in`  in  1  carry-in; sampled on the edge that accepts `start`.
- `busy`  out  1  high while bits are being processed (ADD state).
- `done`  out  1  single-cycle completion pulse (DONE state).
- `s`  out  N  registered sum; updated only on the ADD->DONE transition.
- `c_out`  out  1  registered carry-out; updated together with `s`.

## Operation
- Datapath: operand shift registers `ra`, `rb` (N bits each), carry flip-flop `cy`, sum shift register `rs` (N bits), bit counter `cnt` ($clog2(N+1) bits), one `full_adder` instance fed by `ra[0]`, `rb[0]`, `cy`.
- States: IDLE, ADD, DONE.
- IDLE: `busy`=0, `done`=0. When `start`=1 at an edge: load `ra`<=`a`, `rb`<=`b`, `cy`<=`c_in`, `cnt`<=0, `rs`<=0, and go to ADD.
- ADD: `busy`=1. At each edge: `rs`<={adder sum, `rs[N-1:1]`}; `cy`<=adder carry; shift `ra` and `rb` right by one; `cnt`<=`cnt`+1. On the edge where `cnt`=N-1 (the Nth bit), also load `s`<= the final `rs` value including the current sum bit, load `c_out`<= the adder carry, and go to DONE.
- `start` is ignored in ADD. Operands are not re-sampled and the operation is not restarted.
- DONE: `done`=1 for exactly one cycle. If `start`=1 at that edge, load new operands as in IDLE and go to ADD. Otherwise go to IDLE.
- `s` and `c_out` hold their last result through IDLE and any following ADD, until the next ADD->DONE transition.
- Arithmetic: {`c_out`,`s`} = `a` + `b` + `c_in`, computed modulo 2^(N+1). No overflow flag.
- N=1: ADD lasts exactly one cycle.

## Timing
- Reset values (asynchronous, held while `rst`=1): state IDLE; `busy`=0, `done`=0, `s`=0, `c_out`=0; `ra`, `rb`, `rs`, `cy`, `cnt` all 0.
- Reset asserted mid-ADD aborts the operation. After `rst` deasserts, the block is in IDLE with all outputs 0.
- Latency: `start` accepted at edge E0. ADD occupies the cycles after edges E0..E(N-1). `done`=1 and the new `s`/`c_out` are visible in the cycle after edge EN, i.e. N+1 edges after acceptance.
- Throughput: with `start` held high, the block accepts one new operation every N+1 cycles. `start` accepted in DONE leads to ADD without passing through IDLE.
- Because `s` and `c_out` are registered, no combinational path exists from inputs to outputs.
- `busy` and `done` are never high in the same cycle.

## Test plan
- N=8, `a`=0x00, `b`=0x00, `c_in`=0, one-cycle `start` -> `busy` high for 8 cycles; `done` pulses once, 9 edges after acceptance; `s`=0x00, `c_out`=0.
- N=8, `a`=0xFF, `b`=0x01, `c_in`=0 -> `s`=0x00, `c_out`=1. Then `a`=0xFF, `b`=0xFF, `c_in`=1 -> `s`=0xFF, `c_out`=1. Then `a`=0x5A, `b`=0x3C, `c_in`=0 -> `s`=0x96, `c_out`=0.
- Start `a`=0x12, `b`=0x34, then pulse `start` with `a`=0xFF, `b`=0xFF during ADD -> the second request is ignored; the result is `s`=0x46, `c_out`=0; exactly one `done` pulse.
- Hold `start`=1 with `a`=0x01, `b`=0x01, `c_in`=0 -> `done` pulses every 9 cycles, `s`=0x02 each time, and `busy` is never low between operations except in DONE cycles.
- Assert `rst` during the 4th ADD cycle, after a prior result `s`=0x46 -> `s`, `c_out`, `busy`, `done` are 0 immediately (asynchronous); after release, a new `start` with `a`=0x80, `b`=0x80 gives `s`=0x00, `c_out`=1.
- N=1 and N=2, all `a`, `b`, `c_in` combinations exhaustively -> {`c_out`,`s`} equals `a`+`b`+`c_in` each time; `done` arrives 2 and 3 edges after acceptance, respectively.
